axis_frame_checker: RTL and testbench

//  AXI-Stream sink that terminates a frame stream (e.g. the master side of an axis FIFO) and checks it.

---
 rtl/axis_frame_checker_if.sv | 17 +
 rtl/axis_frame_checker.sv | 138 +++++++++++++
 tb/tb_axis_frame_checker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_checker_if.sv
// axis_if: AXI-Stream bus bundle with master and slave views
interface axis_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  logic [ID_WIDTH-1:0] tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  modport master (output tdata, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave (input tdata, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_frame_checker.sv
// axis_frame_checker: throttled AXI-Stream sink checking seeded incrementing payload, id/dest, length, tuser
// Optional mid-frame idle abort enabled by AXIS_FRAME_CHECKER_TIMEOUT_EN.
module axis_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  axis_if.slave s_axis,
  input  logic cfg_enable,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [7:0] cfg_ready_pattern,
  input  logic [15:0] cfg_max_len,
  output logic frame_good,
  output logic frame_bad,
  output logic err_data,
  output logic err_id,
  output logic err_len,
  output logic err_user,
  output logic err_timeout,
  output logic [15:0] last_len,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);
  typedef enum logic [1:0] {IDLE, SOF, MOF} state_t;
  state_t state;
  logic [2:0] phase;
  logic [DATA_WIDTH-1:0] exp_d;
  logic [ID_WIDTH-1:0] lid;
  logic [DEST_WIDTH-1:0] ldest;
  logic [15:0] len, mlen, len_n, mlen_c;
  logic e_data, e_id, e_len;
  logic sof, beat, fin, d_err, i_err, l_err, u_err, f_data, f_id, f_len, f_bad;
  assign s_axis.tready = (state != IDLE) & cfg_ready_pattern[phase];
  assign sof = state == SOF;
  assign beat = s_axis.tvalid & s_axis.tready;
  assign fin = beat & s_axis.tlast;
  // Seed and length limit come straight from cfg on the first beat, from latched copies afterwards
  assign d_err = s_axis.tdata != (sof ? cfg_seed : exp_d);
  assign i_err = !sof & ((s_axis.tid != lid) | (s_axis.tdest != ldest));
  assign len_n = sof ? 16'd1 : len + {15'd0, ~&len};
  assign mlen_c = sof ? cfg_max_len : mlen;
  assign l_err = (mlen_c != 16'd0) & (len_n > mlen_c);
  assign u_err = &(~(s_axis.tuser ^ USER_BAD_FRAME_VALUE) | ~USER_BAD_FRAME_MASK);
  assign f_data = d_err | (!sof & e_data);
  assign f_id = i_err | (!sof & e_id);
  assign f_len = l_err | (!sof & e_len);
  assign f_bad = f_data | f_id | f_len | u_err;
`ifdef AXIS_FRAME_CHECKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle;
  logic to_hit;
  assign to_hit = (state == MOF) & !beat & (idle == IW'(TIMEOUT_CYCLES - 1));
`else
  assign err_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= 3'd0;
      exp_d <= '0;
      lid <= '0;
      ldest <= '0;
      len <= 16'd0;
      mlen <= 16'd0;
      e_data <= 1'b0;
      e_id <= 1'b0;
      e_len <= 1'b0;
      frame_good <= 1'b0;
      frame_bad <= 1'b0;
      err_data <= 1'b0;
      err_id <= 1'b0;
      err_len <= 1'b0;
      err_user <= 1'b0;
      last_len <= 16'd0;
      good_count <= 16'd0;
      bad_count <= 16'd0;
`ifdef AXIS_FRAME_CHECKER_TIMEOUT_EN
      err_timeout <= 1'b0;
      idle <= '0;
`endif
    end else begin
      phase <= phase + 3'd1;
      frame_good <= 1'b0;
      frame_bad <= 1'b0;
`ifdef AXIS_FRAME_CHECKER_TIMEOUT_EN
      idle <= (state == MOF & !beat) ? idle + IW'(1) : '0;
`endif
      if (state == IDLE) state <= cfg_enable ? SOF : IDLE;
      else if (beat) begin
        exp_d <= (sof ? cfg_seed : exp_d) + DATA_WIDTH'(1);
        len <= len_n;
        e_data <= f_data;
        e_id <= f_id;
        e_len <= f_len;
        if (sof) begin
          lid <= s_axis.tid;
          ldest <= s_axis.tdest;
          mlen <= cfg_max_len;
        end
        if (fin) begin
          state <= cfg_enable ? SOF : IDLE;
          frame_good <= !f_bad;
          frame_bad <= f_bad;
          err_data <= f_data;
          err_id <= f_id;
          err_len <= f_len;
          err_user <= u_err;
          last_len <= len_n;
          good_count <= good_count + {15'd0, !f_bad & ~&good_count};
          bad_count <= bad_count + {15'd0, f_bad & ~&bad_count};
`ifdef AXIS_FRAME_CHECKER_TIMEOUT_EN
          err_timeout <= 1'b0;
`endif
        end else state <= MOF;
      end
`ifdef AXIS_FRAME_CHECKER_TIMEOUT_EN
      else if (to_hit) begin
        state <= cfg_enable ? SOF : IDLE;
        frame_bad <= 1'b1;
        err_data <= e_data;
        err_id <= e_id;
        err_len <= e_len;
        err_user <= 1'b0;
        err_timeout <= 1'b1;
        last_len <= len;
        bad_count <= bad_count + {15'd0, ~&bad_count};
      end
`endif
      else if (sof & !cfg_enable) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_axis_frame_checker.sv
// tb_axis_frame_checker: directed frames with a scoreboard of expected per-frame reports
module tb_axis_frame_checker;
  typedef struct packed {logic good; logic [4:0] err; logic [15:0] len;} exp_t;
  logic clk = 0, rst_n = 0, cfg_enable = 0;
  logic [7:0] cfg_seed = 8'h00, cfg_ready_pattern = 8'hFF;
  logic [15:0] cfg_max_len = 16'd0;
  logic frame_good, frame_bad, err_data, err_id, err_len, err_user, err_timeout;
  logic [15:0] last_len, good_count, bad_count;
  int errors = 0, checks = 0, cyc = 0, acc_cyc = 0, first_cyc = 0, gcnt = 0, bcnt = 0;
  exp_t q[$];
  exp_t me;
  logic [7:0] fd[16], fid[16];
  axis_if #(.DATA_WIDTH(8), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)) s_axis();
  axis_frame_checker #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_axis),
    .cfg_enable(cfg_enable), .cfg_seed(cfg_seed), .cfg_ready_pattern(cfg_ready_pattern),
    .cfg_max_len(cfg_max_len), .frame_good(frame_good), .frame_bad(frame_bad),
    .err_data(err_data), .err_id(err_id), .err_len(err_len), .err_user(err_user),
    .err_timeout(err_timeout), .last_len(last_len), .good_count(good_count), .bad_count(bad_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && (frame_good || frame_bad)) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: good=%0b bad=%0b, required no pulse", frame_good, frame_bad);
      end
      if (q.size() != 0) begin
        me = q.pop_front();
        if (me.good) gcnt++; else bcnt++;
        checks++;
        assert ({frame_good, frame_bad} === {me.good, !me.good}) else begin
          errors++;
          $error("FAIL pulse: got %b required %b", {frame_good, frame_bad}, {me.good, !me.good});
        end
        checks++;
        assert ({err_data, err_id, err_len, err_user, err_timeout} === me.err) else begin
          errors++;
          $error("FAIL err_flags: got %b required %b", {err_data, err_id, err_len, err_user, err_timeout}, me.err);
        end
        checks++;
        assert (last_len === me.len) else begin
          errors++;
          $error("FAIL last_len: got %0d required %0d", last_len, me.len);
        end
        checks++;
        assert ({good_count, bad_count} === {16'(gcnt), 16'(bcnt)}) else begin
          errors++;
          $error("FAIL counters: got good=%0d bad=%0d required good=%0d bad=%0d", good_count, bad_count, gcnt, bcnt);
        end
      end
    end
  end
  task automatic beat(input logic [7:0] d, input logic l, input logic [7:0] id, input logic u);
    int n = 0;
    logic ok;
    s_axis.tdata = d;
    s_axis.tlast = l;
    s_axis.tid = id;
    s_axis.tdest = 8'h5A;
    s_axis.tuser = u;
    s_axis.tvalid = 1'b1;
    do begin
      ok = s_axis.tready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!ok && n < 64);
    acc_cyc = cyc;
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL beat_accept: tready=%0b after %0d cycles, required 1", ok, n);
    end
  endtask
  task automatic fill(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      fd[i] = 8'(start + i);
      fid[i] = 8'h01;
    end
  endtask
  task automatic send_frame(input int n, input logic usr);
    exp_t e;
    logic ed = 1'b0, ei = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (fd[i] !== 8'(cfg_seed + i)) ed = 1'b1;
      if (fid[i] !== fid[0]) ei = 1'b1;
    end
    e.len = 16'(n);
    e.err = {ed, ei, (cfg_max_len != 0) && (n > int'(cfg_max_len)), usr, 1'b0};
    e.good = !(|e.err);
    q.push_back(e);
    for (int i = 0; i < n; i++) begin
      beat(fd[i], i == n - 1, fid[i], (i == n - 1) && usr);
      if (i == 0) first_cyc = acc_cyc;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: %0d reports outstanding, required 0", q.size());
    end
  endtask
  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata = 8'h00;
    s_axis.tlast = 1'b0;
    s_axis.tid = 8'h00;
    s_axis.tdest = 8'h00;
    s_axis.tuser = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    assert (s_axis.tready === 1'b0) else begin
      errors++;
      $error("FAIL reset_tready: got %b required 0", s_axis.tready);
    end
    checks++;
    assert ({good_count, bad_count, last_len} === 48'd0) else begin
      errors++;
      $error("FAIL reset_counts: got %h required 0", {good_count, bad_count, last_len});
    end
    checks++;
    assert ({frame_good, frame_bad, err_data, err_id, err_len, err_user, err_timeout} === 7'd0) else begin
      errors++;
      $error("FAIL reset_flags: got %b required 0", {frame_good, frame_bad, err_data, err_id, err_len, err_user, err_timeout});
    end
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    @(negedge clk);
    cfg_seed = 8'h10;
    fill(8'h10, 4);
    send_frame(4, 1'b0);
    drain();
    cfg_seed = 8'hFE;
    fill(8'hFE, 3);
    send_frame(3, 1'b0);
    fd[2] = 8'h01;
    send_frame(3, 1'b0);
    drain();
    cfg_seed = 8'h10;
    cfg_max_len = 16'd2;
    fill(8'h10, 3);
    send_frame(3, 1'b0);
    cfg_max_len = 16'd3;
    send_frame(3, 1'b0);
    drain();
    cfg_max_len = 16'd0;
    cfg_ready_pattern = 8'b0101_0101;
    cfg_seed = 8'h20;
    fill(8'h20, 8);
    send_frame(8, 1'b0);
    checks++;
    assert (acc_cyc - first_cyc === 14) else begin
      errors++;
      $error("FAIL throttle_span: got %0d cycles required 14", acc_cyc - first_cyc);
    end
    cfg_ready_pattern = 8'hFF;
    drain();
    cfg_seed = 8'h30;
    fill(8'h30, 4);
    fid[2] = 8'h02;
    send_frame(4, 1'b0);
    fill(8'h30, 4);
    send_frame(4, 1'b1);
    drain();
    beat(8'h40, 1'b0, 8'h01, 1'b0);
    beat(8'h41, 1'b0, 8'h01, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    assert (s_axis.tready === 1'b0) else begin
      errors++;
      $error("FAIL midreset_tready: got %b required 0", s_axis.tready);
    end
    checks++;
    assert ({good_count, bad_count} === 32'd0) else begin
      errors++;
      $error("FAIL midreset_counts: got %h required 0", {good_count, bad_count});
    end
    gcnt = 0;
    bcnt = 0;
    s_axis.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_seed = 8'h50;
`ifdef AXIS_FRAME_CHECKER_TIMEOUT_EN
    q.push_back({1'b0, 5'b00001, 16'd2});
    beat(8'h50, 1'b0, 8'h01, 1'b0);
    beat(8'h51, 1'b0, 8'h01, 1'b0);
    s_axis.tvalid = 1'b0;
    repeat (20) @(negedge clk);
    drain();
    fd[0] = 8'h52;
    fid[0] = 8'h01;
    send_frame(1, 1'b0);
`else
    q.push_back({1'b1, 5'b00000, 16'd3});
    beat(8'h50, 1'b0, 8'h01, 1'b0);
    beat(8'h51, 1'b0, 8'h01, 1'b0);
    s_axis.tvalid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    assert (q.size() == 1) else begin
      errors++;
      $error("FAIL stall_no_pulse: outstanding=%0d required 1", q.size());
    end
    beat(8'h52, 1'b1, 8'h01, 1'b0);
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
`endif
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
